// File: rtl/aes_round_sequencer.sv
// Iterative AES-128/192/256 encryption controller: one 128-bit state register, one full round
// per clock. Sequences the initial AddRoundKey, NR-1 full rounds and the final round (no
// MixColumns). Round keys are fetched from an external store addressed by rk_idx.
//
// Optional feature: define AES_SEQ_ABORT_EN to add the abort input.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   abort      (AES_SEQ_ABORT_EN only) drop the block in flight during ROUND/FINAL
//   in_valid   plaintext block valid
//   in_ready   controller can accept a block (IDLE only)
//   in_data    plaintext, byte 0 = [127:120], column c = [127-32c -: 32]
//   rk_idx     round-key index requested this cycle
//   rk_data    round key for rk_idx, combinational, same byte order as in_data
//   out_valid  ciphertext valid (DONE)
//   out_ready  consumer accepts ciphertext
//   out_data   ciphertext (registered state)
//   busy       high in ROUND or FINAL
module aes_round_sequencer #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         reset,
`ifdef AES_SEQ_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : gen_bad_nr
    $error("aes_round_sequencer: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NrIdx  = 4'(NR);
  localparam logic [3:0] NrLast = 4'(NR - 1);

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] sr_w, mc_w;
  logic         abort_w;

`ifdef AES_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) r[127-8*b -: 8] = sbox(s[127-8*b -: 8]);
    return r;
  endfunction

  // Byte (row r, column c) lives at index 4c+r; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  assign sr_w = shift_rows(sub_bytes(blk_q));
  assign mc_w = mix_columns(sr_w);

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    blk_d     = blk_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = 4'd0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d   = in_data ^ rk_data;
          round_d = 4'd1;
          state_d = StRound;
        end
      end
      StRound: begin
        busy   = 1'b1;
        rk_idx = round_q;
        if (abort_w) begin
          blk_d   = '0;
          round_d = 4'd0;
          state_d = StIdle;
        end else begin
          blk_d   = mc_w ^ rk_data;
          round_d = round_q + 4'd1;
          if (round_q == NrLast) state_d = StFinal;
        end
      end
      StFinal: begin
        busy   = 1'b1;
        rk_idx = NrIdx;
        if (abort_w) begin
          blk_d   = '0;
          round_d = 4'd0;
          state_d = StIdle;
        end else begin
          blk_d   = sr_w ^ rk_data;
          round_d = 4'd0;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      round_q <= 4'd0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      blk_q   <= blk_d;
    end
  end

  assign out_data = blk_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;

  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsPt  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FipsCt  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, rk_data, out_data;
  logic [3:0]   rk_idx;
  logic         in_valid14, in_ready14, out_valid14, out_ready14, busy14;
  logic [127:0] rk_data14, out_data14;
  logic [3:0]   rk_idx14;
  logic         abort;
  logic [127:0] rk_mem   [0:15];
  logic [127:0] rk_mem14 [0:15];
  int           checks;
  int           failures;

  assign rk_data   = rk_mem[rk_idx];
  assign rk_data14 = rk_mem14[rk_idx14];

  aes_round_sequencer #(.NR(10)) u_dut (
    .clk       (clk),
    .reset     (reset),
`ifdef AES_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  aes_round_sequencer #(.NR(14)) u_dut14 (
    .clk       (clk),
    .reset     (reset),
`ifdef AES_SEQ_ABORT_EN
    .abort     (1'b0),
`endif
    .in_valid  (in_valid14),
    .in_ready  (in_ready14),
    .in_data   (in_data),
    .rk_idx    (rk_idx14),
    .rk_data   (rk_data14),
    .out_valid (out_valid14),
    .out_ready (out_ready14),
    .out_data  (out_data14),
    .busy      (busy14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX_T[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
  endfunction

  // FIPS-197 key expansion; key words taken from the top of 'key'.
  task automatic load_key(input logic [255:0] key, input int nk, input int nr, input bit to14);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) begin
        if (to14) rk_mem14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        else      rk_mem[r]   = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end else begin
        if (to14) rk_mem14[r] = '0;
        else      rk_mem[r]   = '0;
      end
    end
  endtask

  // Drives one block into the NR=10 instance and consumes its result. edges is the number of
  // rising edges from accept (edge 1) to the first cycle with out_valid, or 0 on timeout.
  task automatic run10(input logic [127:0] pt, output logic [127:0] ct, output int edges);
    int w;
    edges = 0;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    in_data  = pt;
    in_valid = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        edges = n;
        break;
      end
    end
    ct = out_data;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = FipsPt;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0 (block accepted under reset)", busy); end
    checks++;
    if (rk_idx !== 4'd0) begin failures++; $display("FAIL reset_rk_idx got=%0d exp=0", rk_idx); end
    checks++;
    if (in_ready14 !== 1'b1 || busy14 !== 1'b0) begin
      failures++; $display("FAIL reset_nr14 in_ready=%b busy=%b exp 1/0", in_ready14, busy14);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips;
    checks++;
    if (rk_idx !== 4'd0) begin failures++; $display("FAIL fips_rk_idle got=%0d exp=0", rk_idx); end
    in_data  = FipsPt;
    in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (rk_idx !== 4'(k) || out_valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL fips_seq edge=%0d rk_idx=%0d out_valid=%b busy=%b exp rk_idx=%0d 0 1",
                 k, rk_idx, out_valid, busy, k);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL fips_latency out_valid=%b exp=1 after 11 edges", out_valid); end
    checks++;
    if (out_data !== FipsCt) begin failures++; $display("FAIL fips_ct got=%h exp=%h", out_data, FipsCt); end
    checks++;
    if (rk_idx !== 4'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL fips_done rk_idx=%0d busy=%b in_ready=%b exp 0 0 0", rk_idx, busy, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL fips_handshake out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure;
    int n;
    in_data  = FipsPt;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    in_data  = 128'h6bc1bee22e409f96e93d7e117393172a;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== FipsCt || in_ready !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d out_valid=%b in_ready=%b busy=%b data=%h exp 1 0 0 %h",
                 i, out_valid, in_ready, busy, out_data, FipsCt);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b exp 0 1 0", out_valid, in_ready, busy);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || rk_idx !== 4'd1) begin
      failures++; $display("FAIL bp_second_accept busy=%b rk_idx=%0d exp 1 1", busy, rk_idx);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_data !== 128'h3ad77bb40d7a3660a89ecaf32466ef97 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_second_ct got=%h valid=%b exp=3ad77bb40d7a3660a89ecaf32466ef97", out_data, out_valid);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit           hit;
    bit           pulsed;
    logic [127:0] ct;
    int           edges;
    hit = 1'b0;
    in_data  = FipsPt;
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (rk_idx === 4'd5) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rmid_reach_round5 got=0 exp=1"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 128'h0 || busy !== 1'b0 ||
        rk_idx !== 4'd0) begin
      failures++;
      $display("FAIL rmid_state in_ready=%b out_valid=%b busy=%b rk_idx=%0d data=%h exp 1 0 0 0 0",
               in_ready, out_valid, busy, rk_idx, out_data);
    end
    pulsed = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) begin failures++; $display("FAIL rmid_no_out_valid got=1 exp=0"); end
    run10(FipsPt, ct, edges);
    checks++;
    if (ct !== FipsCt || edges != 11) begin
      failures++; $display("FAIL rmid_fresh ct=%h edges=%0d exp %h 11", ct, edges, FipsCt);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] pts [4];
    logic [127:0] cts [4];
    int           acc [4];
    int           idx, nout, cyc;
    bit           accept;
    pts[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    pts[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    pts[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    pts[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    cts[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    cts[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    cts[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
    cts[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
    for (int i = 0; i < 4; i++) acc[i] = 0;
    idx = 0;
    nout = 0;
    cyc = 0;
    in_data   = pts[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (nout < 4 && cyc < 200) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== cts[nout]) begin
          failures++; $display("FAIL b2b_ct idx=%0d got=%h exp=%h", nout, out_data, cts[nout]);
        end
        nout++;
      end
      accept = (in_ready === 1'b1) && in_valid;
      if (accept) acc[idx] = cyc;
      @(negedge clk);
      cyc++;
      if (accept) begin
        idx++;
        if (idx < 4) in_data = pts[idx];
        else         in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (nout != 4 || idx != 4) begin
      failures++; $display("FAIL b2b_count outputs=%0d accepts=%0d exp 4 4", nout, idx);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc[i+1] - acc[i] != 12) begin
        failures++; $display("FAIL b2b_spacing pair=%0d got=%0d exp=12", i, acc[i+1] - acc[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_tail out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
  endtask

`ifdef AES_SEQ_ABORT_EN
  task automatic test_abort;
    bit           hit;
    bit           pulsed;
    logic [127:0] ct;
    int           edges;
    hit = 1'b0;
    in_data  = FipsPt;
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (rk_idx === 4'd10 && busy === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL abort_reach_final got=0 exp=1"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 128'h0) begin
      failures++;
      $display("FAIL abort_state in_ready=%b busy=%b out_valid=%b data=%h exp 1 0 0 0",
               in_ready, busy, out_valid, out_data);
    end
    pulsed = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) begin failures++; $display("FAIL abort_no_out_valid got=1 exp=0"); end
    run10(128'hae2d8a571e03ac9c9eb76fac45af8e51, ct, edges);
    checks++;
    if (ct !== 128'hf5d3d58503b9699de785895a96fdbaaf || edges != 11) begin
      failures++; $display("FAIL abort_fresh ct=%h edges=%0d exp f5d3d58503b9699de785895a96fdbaaf 11", ct, edges);
    end
    // Abort while DONE must not drop the pending result.
    in_data  = FipsPt;
    in_valid = 1'b1;
    edges = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== FipsCt) begin
      failures++; $display("FAIL abort_in_done out_valid=%b data=%h exp 1 %h", out_valid, out_data, FipsCt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
`endif

  task automatic test_vectors;
    logic [127:0] ct;
    int           edges;
    logic [3:0]   rk_final;
    load_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10, 1'b0);
    run10(128'h00112233445566778899aabbccddeeff, ct, edges);
    checks++;
    if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a || edges != 11) begin
      failures++; $display("FAIL vec128 ct=%h edges=%0d exp 69c4e0d86a7b0430d8cdb78070b4c55a 11", ct, edges);
    end
    load_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, 1'b1);
    in_data    = 128'h00112233445566778899aabbccddeeff;
    in_valid14 = 1'b1;
    edges = 0;
    rk_final = 4'd0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      in_valid14 = 1'b0;
      if (n == 14) rk_final = rk_idx14;
      if (out_valid14 === 1'b1) begin
        edges = n;
        break;
      end
    end
    checks++;
    if (rk_final !== 4'd14) begin failures++; $display("FAIL vec256_final_rk got=%0d exp=14", rk_final); end
    checks++;
    if (out_data14 !== 128'h8ea2b7ca516745bfeafc49904b496089 || edges != 15) begin
      failures++;
      $display("FAIL vec256 ct=%h edges=%0d exp 8ea2b7ca516745bfeafc49904b496089 15", out_data14, edges);
    end
    out_ready14 = 1'b1;
    @(negedge clk);
    out_ready14 = 1'b0;
    checks++;
    if (out_valid14 !== 1'b0 || in_ready14 !== 1'b1) begin
      failures++; $display("FAIL vec256_handshake out_valid=%b in_ready=%b exp 0 1", out_valid14, in_ready14);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    in_valid14  = 1'b0;
    out_ready14 = 1'b0;
    abort       = 1'b0;
    load_key({FipsKey, 128'h0}, 4, 10, 1'b0);
    load_key({FipsKey, 128'h0}, 4, 10, 1'b1);
    test_reset();
    test_fips();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef AES_SEQ_ABORT_EN
    test_abort();
`endif
    test_vectors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
